// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU control codes, mul/div FSM encoding and decode helper
package cpu_pkg;
  localparam logic [4:0] ALUCTRL_ADD  = 5'd2;
  localparam logic [4:0] ALUCTRL_MUL  = 5'd3;
  localparam logic [4:0] ALUCTRL_MULU = 5'd4;
  localparam logic [4:0] ALUCTRL_DIV  = 5'd5;
  localparam logic [4:0] ALUCTRL_DIVU = 5'd6;
  localparam logic [4:0] ALUCTRL_REM  = 5'd7;
  localparam logic [4:0] ALUCTRL_REMU = 5'd8;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_e;
  function automatic logic is_muldiv(input logic [4:0] code);
    return code >= ALUCTRL_MUL && code <= ALUCTRL_REMU;
  endfunction
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: radix-2 shift-add multiply / restoring divide datapath, one step per cycle
module md_iter_core #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            mul_i,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic [BITS-1:0] hi_d_o,
  output logic [BITS-1:0] lo_d_o
);
  logic [BITS-1:0] hi_q, lo_q, b_q;
  logic [BITS:0] sum, shl, diff;
  // hi holds the product high word / partial remainder; lo the multiplier / quotient
  always_comb begin
    sum = {1'b0, hi_q} + {1'b0, b_q};
    shl = {hi_q, lo_q[BITS-1]};
    diff = shl - {1'b0, b_q};
    hi_d_o = mul_i ? (lo_q[0] ? sum[BITS:1] : {1'b0, hi_q[BITS-1:1]})
                   : (diff[BITS] ? shl[BITS-1:0] : diff[BITS-1:0]);
    lo_d_o = mul_i ? {lo_q[0] ? sum[0] : hi_q[0], lo_q[BITS-1:1]}
                   : {lo_q[BITS-2:0], ~diff[BITS]};
  end
  always_ff @(posedge clk)
    if (rst) {hi_q, lo_q, b_q} <= '0;
    else if (load_i) {hi_q, lo_q, b_q} <= {{BITS{1'b0}}, a_i, b_i};
    else if (step_i) {hi_q, lo_q} <= {hi_d_o, lo_d_o};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: stalls the pipeline while an iterative MUL/DIV/REM runs beside the ALU
module muldiv_sequencer
  import cpu_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [4:0]      alu_ctrl_i,
  input  logic [BITS-1:0] src_a_i,
  input  logic [BITS-1:0] src_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [BITS-1:0] result_o
);
  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0] op_q;
  logic neg_q, sa_q;
  logic [BITS-1:0] result_q, a_op, b_op, sc_val, fin, hi_d, lo_d;
  logic is_md, start, is_div, is_sdiv, b_zero, shortcut, step, mul;
  always_comb begin
    is_md = valid_i && is_muldiv(alu_ctrl_i);
    start = state_q == MD_IDLE && is_md && !flush_i;
    is_div = alu_ctrl_i >= ALUCTRL_DIV;
    is_sdiv = alu_ctrl_i == ALUCTRL_DIV || alu_ctrl_i == ALUCTRL_REM;
    b_zero = src_b_i == '0;
    shortcut = is_div && (b_zero || (is_sdiv && src_a_i == MIN_NEG && &src_b_i));
    sc_val = b_zero ? ((alu_ctrl_i == ALUCTRL_DIV || alu_ctrl_i == ALUCTRL_DIVU) ? '1 : src_a_i)
                    : (alu_ctrl_i == ALUCTRL_DIV ? src_a_i : '0);
    a_op = is_sdiv && src_a_i[BITS-1] ? -src_a_i : src_a_i;
    b_op = is_sdiv && src_b_i[BITS-1] ? -src_b_i : src_b_i;
    step = state_q == MD_CALC && !flush_i;
    mul = op_q == ALUCTRL_MUL || op_q == ALUCTRL_MULU;
    // final step's core outputs feed the result so it lands on the edge entering DONE
    fin = op_q == ALUCTRL_MUL  ? lo_d :
          op_q == ALUCTRL_MULU ? hi_d :
          op_q == ALUCTRL_DIV  ? (neg_q ? -lo_d : lo_d) :
          op_q == ALUCTRL_DIVU ? lo_d :
          op_q == ALUCTRL_REM  ? (sa_q ? -hi_d : hi_d) : hi_d;
  end
  md_iter_core #(.BITS(BITS)) u_core (
    .clk(clk), .rst(rst), .load_i(start), .step_i(step), .mul_i(mul),
    .a_i(a_op), .b_i(b_op), .hi_d_o(hi_d), .lo_d_o(lo_d)
  );
  always_ff @(posedge clk)
    if (rst) state_q <= MD_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == MD_IDLE ? (start ? (shortcut ? MD_DONE : MD_CALC) : MD_IDLE) :
              state_q == MD_CALC ? (flush_i ? MD_IDLE : cnt_q == '0 ? MD_DONE : MD_CALC) :
              MD_IDLE;
  always_comb begin
    stall_o = state_q == MD_IDLE ? start : state_q == MD_CALC;
    busy_o = state_q != MD_IDLE;
    done_o = state_q == MD_DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      sa_q <= 1'b0;
      result_q <= '0;
    end else if (start) begin
      op_q <= alu_ctrl_i;
      neg_q <= src_a_i[BITS-1] ^ src_b_i[BITS-1];
      sa_q <= src_a_i[BITS-1];
      cnt_q <= CNT_W'(BITS - 1);
      if (shortcut) result_q <= sc_val;
    end else if (step) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else result_q <= fin;
    end
  assign result_o = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
  logic clk = 0, rst = 1, valid_i = 0, flush_i = 0;
  logic [4:0] alu_ctrl_i = 0;
  logic [31:0] src_a_i = 0, src_b_i = 0;
  logic stall_o, busy_o, done_o;
  logic [31:0] result_o;
  int tests = 0, fails = 0, cyc = 0, last_done = 0;
  logic [31:0] last_exp = 0;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .alu_ctrl_i(alu_ctrl_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, b);
    logic [63:0] p;
    int sa, sb;
    logic ovf;
    p = 64'(a) * 64'(b);
    sa = a;
    sb = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      5'd3: return p[31:0];
      5'd4: return p[63:32];
      5'd5: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      5'd6: return b == 0 ? 32'hFFFF_FFFF : a / b;
      5'd7: return b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, b);
    if (op >= 5 && (b == 0 || ((op == 5 || op == 7) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issues one op, scrambles inputs while stalled, and checks latency, result and stall window
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a, b, exp);
    int lat;
    logic stall_ok;
    @(negedge clk);
    valid_i = 1; alu_ctrl_i = op; src_a_i = a; src_b_i = b; flush_i = 0;
    #1 check({tag, "_stall_req"}, 32'(stall_o), 1);
    lat = 0;
    stall_ok = 1;
    do begin
      @(negedge clk);
      lat++;
      if (!done_o) begin
        stall_ok &= stall_o === 1'b1;
        alu_ctrl_i = 5'($urandom); src_a_i = $urandom; src_b_i = $urandom;
      end
    end while (!done_o && lat < 40);
    last_done = cyc;
    check({tag, "_lat"}, 32'(lat), 32'(model_lat(op, a, b)));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_stall_win"}, 32'(stall_ok), 1);
    check({tag, "_done_stall"}, 32'({stall_o, busy_o}), 32'b01);
    valid_i = 0;
    last_exp = exp;
  endtask

  initial begin
    int d1, nd;
    logic [4:0] op;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_result", result_o, 0);
    rst = 0;

    do_op("mul_7_m3", 5'd3, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulu_max", 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("div_m7_2", 5'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 5'd7, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("divu_100_7", 5'd6, 32'd100, 32'd7, 32'd14);
    do_op("remu_100_7", 5'd8, 32'd100, 32'd7, 32'd2);
    do_op("divu_by0", 5'd6, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("rem_by0", 5'd7, 32'd5, 32'd0, 32'd5);
    do_op("div_ovf", 5'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf", 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // flush in CALC aborts without done and keeps the previous result
    @(negedge clk);
    valid_i = 1; alu_ctrl_i = 5'd5; src_a_i = 32'd1000; src_b_i = 32'd3;
    @(negedge clk); valid_i = 0;
    repeat (8) @(negedge clk);
    check("flush_busy_before", 32'(busy_o), 1);
    @(negedge clk); valid_i = 1; flush_i = 1;
    @(negedge clk); valid_i = 0; flush_i = 0;
    #1 check("flush_idle", 32'({stall_o, busy_o, done_o}), 0);
    check("flush_result_kept", result_o, last_exp);
    nd = 0;
    repeat (40) begin @(negedge clk); nd += int'(done_o); end
    check("flush_no_done", 32'(nd), 0);

    // reset mid-multiply
    @(negedge clk);
    valid_i = 1; alu_ctrl_i = 5'd3; src_a_i = 32'd123; src_b_i = 32'd456;
    @(negedge clk); valid_i = 0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy", 32'(busy_o), 1);
    rst = 1;
    @(negedge clk);
    check("rst_mid_outs", 32'({stall_o, busy_o, done_o}), 0);
    check("rst_mid_result", result_o, 0);
    rst = 0;

    // back-to-back: second done 34 cycles after the first
    do_op("b2b_mul", 5'd3, 32'd9, 32'd11, 32'd99);
    d1 = last_done;
    do_op("b2b_divu", 5'd6, 32'd99, 32'd10, 32'd9);
    check("b2b_gap", 32'(last_done - d1), 32'd34);

    // non-muldiv code never stalls
    @(negedge clk);
    valid_i = 1; alu_ctrl_i = 5'd2;
    repeat (5) begin
      src_a_i = $urandom; src_b_i = $urandom;
      #1 check("add_no_stall", 32'({stall_o, busy_o}), 0);
      @(negedge clk);
    end
    valid_i = 0;

    repeat (30) begin
      op = 5'(3 + $urandom_range(0, 5));
      a = $urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_op("rand", op, a, b, model(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
